// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the RV32I data bus.
// Byte writes to TXDATA are queued in a small circular FIFO and serialised
// LSB first on tx. STATUS = {28'b0, overflow, full, empty, busy}.
// Optional feature macro: MMIO_UART_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit times).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef logic [PW:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef MMIO_UART_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            push_req;
  logic            push;
  logic            pop;
  logic            stat_wr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            baud_end;
  logic [7:0]      head_byte;

  // Byte offsets and the upper store-data bits carry no meaning here.
  logic            unused_bits;
  assign unused_bits = ^{addr[1:0], wd[31:8]};

  // Word-granular decode of the 8-byte register window.
  assign sel      = (addr[31:3] == BASE_ADDR[31:3]);
  assign push_req = we & sel & ~addr[2];
  assign stat_wr  = we & sel &  addr[2];

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // Fullness is sampled before any same-edge pop, so a write to a full FIFO
  // is dropped even while the transmitter is taking the head entry.
  assign push      = push_req & ~fifo_full;
  assign head_byte = mem_q[rd_ptr_q[PW-1:0]];
  assign baud_end  = (baud_q == BAUD_MAX);

  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;
  assign rdata = (sel && addr[2]) ? {28'b0, ovf_q, fifo_full, fifo_empty, busy} : '0;

  // FIFO pointer and sticky-overflow next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (stat_wr && wd[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wd[7:0];
    end
  end

  // Transmit FSM next-state logic: baud counter, bit index, shift register.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef MMIO_UART_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head_byte;
          baud_d   = '0;
          bitidx_d = '0;
`ifdef MMIO_UART_PARITY_EN
          par_d    = ^head_byte;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so tx is a clean flop output
  // that changes on the same edge as the state register.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, pointers and line register; reset aborts any frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus decode, frame timing, FIFO overflow,
// asynchronous reset abort and (with MMIO_UART_PARITY_EN) the parity bit.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0080;
`ifdef MMIO_UART_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Frames as {stop, parity, data}; parity slot is 0 for 8N1 builds.
  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .sel  (sel),
    .rdata(rdata),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Serial receiver: locks on the first low sample, samples mid-bit.
  logic       mon_active = 1'b0;
  int         mon_cnt;
  logic [7:0] mon_byte;
  logic       mon_par;
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
        mon_par    = 1'b0;
      end
    end else begin
      mon_cnt++;
      for (int k = 0; k < 8; k++) begin
        if (mon_cnt == CPB * (1 + k) + CPB / 2) mon_byte[k] = tx;
      end
      if (FRAME_BITS == 11 && mon_cnt == CPB * 9 + CPB / 2) mon_par = tx;
      if (mon_cnt == CPB * (FRAME_BITS - 1) + CPB / 2) begin
        rx_q.push_back({tx, mon_par, mon_byte});
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(negedge clk);
  endtask

  task automatic idle_bus();
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
    we   = 1'b0;
    addr = a;
    #1;
    chk(tag, rdata, expv);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic score(input string tag);
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
`ifdef MMIO_UART_PARITY_EN
    return {1'b1, ^b, b};
`else
    return {1'b1, 1'b0, b};
`endif
  endfunction

  initial begin
    int         len;
    logic [7:0] b;
    reset = 1'b1;
    idle_bus();
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rd("rst_status", BASE + 4, 32'h2);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: decode boundaries and an out-of-window store.
    rd("t1_status", BASE + 4, 32'h2);
    rd("t1_txdata_read", BASE, 32'h0);
    chk("t1_sel_base", 32'(sel), 32'd1);
    rd("t1_base7_read", BASE + 7, 32'h2);
    chk("t1_sel_base7", 32'(sel), 32'd1);
    rd("t1_base8_read", BASE + 8, 32'h0);
    chk("t1_sel_base8", 32'(sel), 32'd0);
    addr = BASE + 16;
    #1;
    chk("t1_sel_base16", 32'(sel), 32'd0);
    wr(BASE + 16, 32'h0000_0041);
    idle_bus();
    repeat (3) @(negedge clk);
    chk("t1_tx_idle", 32'(tx), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    rd("t1_status_after", BASE + 4, 32'h2);

    // Test 2: cycle-exact frame of 0x55 with upper data bits set.
    @(negedge clk);
    b = 8'h55;
    wr(BASE, 32'hFFFF_FF55);
    idle_bus();
    exp_q.push_back(frame(b));
    chk("t2_tx_write_cycle", 32'(tx), 32'd1);
    chk("t2_busy_write_cycle", 32'(busy), 32'd0);
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      int   bi;
      logic e;
      @(negedge clk);
      bi = i / CPB;
      if (bi == 0) e = 1'b0;
      else if (bi <= 8) e = b[bi - 1];
      else if (bi == FRAME_BITS - 1) e = 1'b1;
      else e = ^b;
      chk("t2_tx_bit", 32'(tx), 32'(e));
      chk("t2_busy_frame", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_tx_after", 32'(tx), 32'd1);
    wait_rx("t2_rx_count", 1, 20);
    score("t2_frame");

    // Test 3: six back-to-back stores into a depth-4 FIFO.
    @(negedge clk);
    wr(BASE, 32'h01);
    chk("t3_busy_edgeN", 32'(busy), 32'd0);
    wr(BASE, 32'h02);
    chk("t3_busy_edgeN1", 32'(busy), 32'd1);
    chk("t3_tx_start", 32'(tx), 32'd0);
    for (int v = 3; v <= 6; v++) begin
      wr(BASE, 32'(v));
    end
    idle_bus();
    for (int v = 1; v <= 5; v++) begin
      exp_q.push_back(frame(8'(v)));
    end
    rd("t3_status_full_ovf", BASE + 4, 32'hD);

    // Test 4: clear overflow while full, then drain.
    @(negedge clk);
    wr(BASE + 4, 32'h8);
    idle_bus();
    rd("t4_status_ovf_clr", BASE + 4, 32'h5);
    wait_rx("t3_rx_count", 5, 5 * FRAME_BITS * CPB + 40);
    repeat (CPB + 2) @(negedge clk);
    rd("t4_status_drained", BASE + 4, 32'h2);
    score("t3_order");
    repeat (2 * FRAME_BITS * CPB) @(negedge clk);
    chk("t3_no_extra", 32'(rx_q.size()), 32'd0);

    // Test 5: asynchronous reset during data bit 3 with two bytes queued.
    wr(BASE, 32'hA1);
    wr(BASE, 32'hA2);
    wr(BASE, 32'hA3);
    idle_bus();
    repeat (16) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_tx_pre", 32'(tx), 32'd0);
    rd("t5_status_pre", BASE + 4, 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_tx_async", 32'(tx), 32'd1);
    chk("t5_busy_async", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd("t5_status_post", BASE + 4, 32'h2);
    repeat (3 * FRAME_BITS * CPB) @(negedge clk);
    chk("t5_no_frames", 32'(rx_q.size()), 32'd0);
    chk("t5_tx_idle", 32'(tx), 32'd1);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    // Test 6: frame length and parity bit for 0x07 and 0x03.
    wr(BASE, 32'h07);
    idle_bus();
`ifdef MMIO_UART_PARITY_EN
    exp_q.push_back({1'b1, 1'b1, 8'h07});
    exp_q.push_back({1'b1, 1'b0, 8'h03});
`else
    exp_q.push_back(frame(8'h07));
    exp_q.push_back(frame(8'h03));
`endif
    len = 0;
    @(negedge clk);
    while (busy === 1'b1 && len < 200) begin
      len++;
      @(negedge clk);
    end
    chk("t6_frame_len", 32'(len), 32'(FRAME_BITS * CPB));
    wr(BASE, 32'h03);
    idle_bus();
    wait_rx("t6_rx_count", 2, FRAME_BITS * CPB + 20);
    score("t6_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
